// File: rtl/saw_br_pkg.sv
// -----------------------------------------------------------------------------
// saw_br_pkg -- shared definitions for the control sequencer.
//   * opcode constants (4-bit upper nibble of the instruction register)
//   * T-state enumeration (T1..T6 plus terminal HALT)
//   * ALU-select constants, ordered {xor_not, add_sub, alu1_or, alu0_and}
//   * control-word struct and small decode helpers
// Optional feature macro used by the sequencer: COND_JUMP_EN (JZ/JC decode).
// -----------------------------------------------------------------------------
package saw_br_pkg;

  localparam int DATA_W = 8;
  localparam int OPC_W  = 4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_STA = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_T1   = 3'd0,
    ST_T2   = 3'd1,
    ST_T3   = 3'd2,
    ST_T4   = 3'd3,
    ST_T5   = 3'd4,
    ST_T6   = 3'd5,
    ST_HALT = 3'd6
  } tstate_e;

  // {xor_not, add_sub, alu1_or, alu0_and}
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOT  = 4'b1011;
  localparam logic [3:0] ALU_NONE = 4'b0000;

  typedef struct packed {
    logic       pc_out;
    logic       pc_inc;
    logic       pc_load;
    logic       mar_load;
    logic       ram_out;
    logic       ram_load;
    logic       ir_load;
    logic       ir_out;
    logic       acc_load;
    logic       acc_out;
    logic       b_load;
    logic       alu_out;
    logic [3:0] alu_sel;
    logic       out_load;
  } ctrl_t;

  // Two-operand ALU select for opcodes ADD..XOR; anything else maps to zero.
  function automatic logic [3:0] alu_sel_of(input logic [3:0] op);
    logic [3:0] sel;
    case (op)
      OP_ADD:  sel = ALU_ADD;
      OP_SUB:  sel = ALU_SUB;
      OP_AND:  sel = ALU_AND;
      OP_OR:   sel = ALU_OR;
      OP_XOR:  sel = ALU_XOR;
      default: sel = ALU_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/control_sequencer_tstate_counter.sv
// -----------------------------------------------------------------------------
// tstate_counter -- T-state register for the control sequencer.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset (state -> T1)
//   en          advance enable; 0 holds the current state
//   last_step   current state is the final execute state -> return to T1
//   halt_req    current state executes HLT -> enter HALT
//   state       current T-state
// HALT is absorbing; only reset leaves it.
// -----------------------------------------------------------------------------
module tstate_counter
  import saw_br_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en,
  input  logic    last_step,
  input  logic    halt_req,
  output tstate_e state
);

  tstate_e state_r;
  tstate_e state_next_s;

  // Next-state selection: hold, halt, early return to T1, or sequential advance.
  always_comb begin
    state_next_s = state_r;
    if (!en) begin
      state_next_s = state_r;
    end else if (state_r == ST_HALT) begin
      state_next_s = ST_HALT;
    end else if (halt_req) begin
      state_next_s = ST_HALT;
    end else if (last_step) begin
      state_next_s = ST_T1;
    end else begin
      case (state_r)
        ST_T1:   state_next_s = ST_T2;
        ST_T2:   state_next_s = ST_T3;
        ST_T3:   state_next_s = ST_T4;
        ST_T4:   state_next_s = ST_T5;
        ST_T5:   state_next_s = ST_T6;
        default: state_next_s = ST_T1;  // T6 and any stray encoding recover to fetch
      endcase
    end
  end

  // State register with asynchronous reset to T1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_T1;
    end else begin
      state_r <= state_next_s;
    end
  end

  assign state = state_r;

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer -- microcoded-style control unit for an 8-bit SAP machine.
// Decodes the T-state and IR opcode nibble into bus-drive / load / ALU-select
// strobes. Fetch is T1 (pc_out, mar_load) and T2 (ram_out, ir_load, pc_inc);
// execute runs from T3 and returns to T1 after the instruction's last state.
// Ports:
//   clk, rst_n, step_en         clock, async active-low reset, advance enable
//   ir_opcode, zero_flag,
//   carry_flag                  opcode nibble and ALU flags
//   pc_*, mar_load, ram_*,
//   ir_*, acc_*, b_load,
//   alu_out, add_sub, alu0_and,
//   alu1_or, xor_not, out_load  control strobes (all 0 when step_en=0 or reset)
//   halted                      HLT executed; cleared only by reset
// Macro COND_JUMP_EN: when defined, opcodes A (JZ) and B (JC) load the PC from
// the IR operand if zero_flag / carry_flag is set; otherwise they act as NOP.
// -----------------------------------------------------------------------------
module control_sequencer
  import saw_br_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_en,
  input  logic [3:0] ir_opcode,
  input  logic       zero_flag,
  input  logic       carry_flag,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ram_load,
  output logic       ir_load,
  output logic       ir_out,
  output logic       acc_load,
  output logic       acc_out,
  output logic       b_load,
  output logic       alu_out,
  output logic       add_sub,
  output logic       alu0_and,
  output logic       alu1_or,
  output logic       xor_not,
  output logic       out_load,
  output logic       halted
);

  tstate_e state_s;
  ctrl_t   ctrl_s;
  logic    last_s;
  logic    halt_s;
  logic    active_s;

`ifndef COND_JUMP_EN
  // Flags are only consumed by the conditional jumps.
  logic    unused_flags_s;
  assign unused_flags_s = zero_flag ^ carry_flag;
`endif

  tstate_counter u_tstate (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (step_en),
    .last_step (last_s),
    .halt_req  (halt_s),
    .state     (state_s)
  );

  // Control decode: one control word per (state, opcode) plus end-of-instruction flags.
  always_comb begin
    ctrl_s = '0;
    last_s = 1'b0;
    halt_s = 1'b0;
    case (state_s)
      ST_T1: begin
        ctrl_s.pc_out   = 1'b1;
        ctrl_s.mar_load = 1'b1;
      end
      ST_T2: begin
        ctrl_s.ram_out = 1'b1;
        ctrl_s.ir_load = 1'b1;
        ctrl_s.pc_inc  = 1'b1;
      end
      ST_T3: begin
        case (ir_opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_STA: begin
            ctrl_s.ir_out   = 1'b1;
            ctrl_s.mar_load = 1'b1;
          end
          OP_NOT: begin
            ctrl_s.alu_out  = 1'b1;
            ctrl_s.acc_load = 1'b1;
            ctrl_s.alu_sel  = ALU_NOT;
            last_s          = 1'b1;
          end
          OP_JMP: begin
            ctrl_s.ir_out  = 1'b1;
            ctrl_s.pc_load = 1'b1;
            last_s         = 1'b1;
          end
`ifdef COND_JUMP_EN
          OP_JZ: begin
            ctrl_s.ir_out  = zero_flag;
            ctrl_s.pc_load = zero_flag;
            last_s         = 1'b1;
          end
          OP_JC: begin
            ctrl_s.ir_out  = carry_flag;
            ctrl_s.pc_load = carry_flag;
            last_s         = 1'b1;
          end
`endif
          OP_OUT: begin
            ctrl_s.acc_out  = 1'b1;
            ctrl_s.out_load = 1'b1;
            last_s          = 1'b1;
          end
          OP_HLT: begin
            halt_s = 1'b1;
          end
          default: begin
            last_s = 1'b1;  // NOP, C, D (and A/B without conditional jumps)
          end
        endcase
      end
      ST_T4: begin
        case (ir_opcode)
          OP_LDA: begin
            ctrl_s.ram_out  = 1'b1;
            ctrl_s.acc_load = 1'b1;
            last_s          = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            ctrl_s.ram_out = 1'b1;
            ctrl_s.b_load  = 1'b1;
          end
          OP_STA: begin
            ctrl_s.acc_out  = 1'b1;
            ctrl_s.ram_load = 1'b1;
            last_s          = 1'b1;
          end
          default: begin
            last_s = 1'b1;
          end
        endcase
      end
      ST_T5: begin
        case (ir_opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            ctrl_s.alu_out  = 1'b1;
            ctrl_s.acc_load = 1'b1;
            ctrl_s.alu_sel  = alu_sel_of(ir_opcode);
            last_s          = 1'b1;
          end
          default: begin
            last_s = 1'b1;
          end
        endcase
      end
      ST_HALT: begin
        ctrl_s = '0;
      end
      default: begin
        last_s = 1'b1;  // T6 is never reached by a legal opcode; recover quietly
      end
    endcase
  end

  // Strobes only fire on cycles that actually advance, and never during reset.
  assign active_s = step_en & rst_n;

  assign pc_out   = ctrl_s.pc_out      & active_s;
  assign pc_inc   = ctrl_s.pc_inc      & active_s;
  assign pc_load  = ctrl_s.pc_load     & active_s;
  assign mar_load = ctrl_s.mar_load    & active_s;
  assign ram_out  = ctrl_s.ram_out     & active_s;
  assign ram_load = ctrl_s.ram_load    & active_s;
  assign ir_load  = ctrl_s.ir_load     & active_s;
  assign ir_out   = ctrl_s.ir_out      & active_s;
  assign acc_load = ctrl_s.acc_load    & active_s;
  assign acc_out  = ctrl_s.acc_out     & active_s;
  assign b_load   = ctrl_s.b_load      & active_s;
  assign alu_out  = ctrl_s.alu_out     & active_s;
  assign xor_not  = ctrl_s.alu_sel[3]  & active_s;
  assign add_sub  = ctrl_s.alu_sel[2]  & active_s;
  assign alu1_or  = ctrl_s.alu_sel[1]  & active_s;
  assign alu0_and = ctrl_s.alu_sel[0]  & active_s;
  assign out_load = ctrl_s.out_load    & active_s;
  assign halted   = rst_n & (state_s == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer -- self-checking bench for control_sequencer.
// A per-instruction reference model expands each opcode into its list of
// expected control words (fetch + execute) and the bench walks that list,
// inserting stall cycles and scrambling the opcode during fetch.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       step_en = 1'b0;
  logic [3:0] ir_opcode = 4'h0;
  logic       zero_flag = 1'b0;
  logic       carry_flag = 1'b0;
  logic pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load, ir_load, ir_out;
  logic acc_load, acc_out, b_load, alu_out, add_sub, alu0_and, alu1_or, xor_not;
  logic out_load, halted;

  int checks = 0;
  int errors = 0;

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .step_en(step_en), .ir_opcode(ir_opcode),
    .zero_flag(zero_flag), .carry_flag(carry_flag),
    .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
    .ram_out(ram_out), .ram_load(ram_load), .ir_load(ir_load), .ir_out(ir_out),
    .acc_load(acc_load), .acc_out(acc_out), .b_load(b_load), .alu_out(alu_out),
    .add_sub(add_sub), .alu0_and(alu0_and), .alu1_or(alu1_or), .xor_not(xor_not),
    .out_load(out_load), .halted(halted)
  );

  always #5 clk = ~clk;

  // Bench view of the strobes; ALU select sits at bits [4:1] as {xor_not,add_sub,alu1_or,alu0_and}.
  logic [16:0] dut_vec;
  assign dut_vec = {pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load, ir_load, ir_out,
                    acc_load, acc_out, b_load, alu_out, xor_not, add_sub, alu1_or, alu0_and,
                    out_load};

  localparam logic [16:0] M_PC_OUT   = 17'h10000;
  localparam logic [16:0] M_PC_INC   = 17'h08000;
  localparam logic [16:0] M_PC_LOAD  = 17'h04000;
  localparam logic [16:0] M_MAR      = 17'h02000;
  localparam logic [16:0] M_RAM_OUT  = 17'h01000;
  localparam logic [16:0] M_RAM_LOAD = 17'h00800;
  localparam logic [16:0] M_IR_LOAD  = 17'h00400;
  localparam logic [16:0] M_IR_OUT   = 17'h00200;
  localparam logic [16:0] M_ACC_LOAD = 17'h00100;
  localparam logic [16:0] M_ACC_OUT  = 17'h00080;
  localparam logic [16:0] M_B_LOAD   = 17'h00040;
  localparam logic [16:0] M_ALU_OUT  = 17'h00020;
  localparam logic [16:0] M_OUT_LOAD = 17'h00001;

  logic [16:0] exp_q[$];
  bit          exp_halts;
  bit          mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] sel_bits(input logic [3:0] sel);
    return {12'd0, sel, 1'b0};
  endfunction

  // Reference model: the full list of control words an instruction produces.
  task automatic build(input logic [3:0] op, input bit zf, input bit cf);
    logic [16:0] jmp_w;
    exp_q.delete();
    exp_halts = 1'b0;
    exp_q.push_back(M_PC_OUT | M_MAR);
    exp_q.push_back(M_RAM_OUT | M_IR_LOAD | M_PC_INC);
    jmp_w = M_IR_OUT | M_PC_LOAD;
    case (op)
      4'h1: begin
        exp_q.push_back(M_IR_OUT | M_MAR);
        exp_q.push_back(M_RAM_OUT | M_ACC_LOAD);
      end
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
        exp_q.push_back(M_IR_OUT | M_MAR);
        exp_q.push_back(M_RAM_OUT | M_B_LOAD);
        exp_q.push_back(M_ALU_OUT | M_ACC_LOAD |
                        sel_bits(op == 4'h2 ? 4'b0000 : op == 4'h3 ? 4'b0100 :
                                 op == 4'h4 ? 4'b0001 : op == 4'h5 ? 4'b0010 : 4'b0011));
      end
      4'h7: exp_q.push_back(M_ALU_OUT | M_ACC_LOAD | sel_bits(4'b1011));
      4'h8: begin
        exp_q.push_back(M_IR_OUT | M_MAR);
        exp_q.push_back(M_ACC_OUT | M_RAM_LOAD);
      end
      4'h9: exp_q.push_back(jmp_w);
`ifdef COND_JUMP_EN
      4'hA: exp_q.push_back(zf ? jmp_w : 17'd0);
      4'hB: exp_q.push_back(cf ? jmp_w : 17'd0);
`endif
      4'hE: exp_q.push_back(M_ACC_OUT | M_OUT_LOAD);
      4'hF: begin
        exp_q.push_back(17'd0);
        exp_halts = 1'b1;
      end
      default: exp_q.push_back(17'd0);
    endcase
  endtask

  task automatic do_cycle(input bit en, input logic [3:0] op, input logic [16:0] ev,
                          input bit eh, input string tag);
    @(negedge clk);
    step_en = en;
    ir_opcode = op;
    #1;
    chk(tag, {14'd0, halted, dut_vec}, {14'd0, eh, ev});
  endtask

  task automatic run_instr(input logic [3:0] op, input bit zf, input bit cf,
                           input int stall_at, input int stall_len, input bit rnd);
    int n;
    logic [3:0] drv;
    zero_flag = zf;
    carry_flag = cf;
    build(op, zf, cf);
    for (int i = 0; i < exp_q.size(); i++) begin
      drv = (i < 2) ? 4'($urandom) : op;
      n = (i == stall_at) ? stall_len : 0;
      if (rnd && $urandom_range(0, 5) == 0) n += $urandom_range(1, 2);
      for (int s = 0; s < n; s++) do_cycle(1'b0, drv, 17'd0, 1'b0, "stall");
      do_cycle(1'b1, drv, exp_q[i], 1'b0, $sformatf("op%h_s%0d", op, i));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    step_en = 1'b1;
    #1;
    chk("rst", {14'd0, halted, dut_vec}, 32'd0);
    @(negedge clk);
    #1;
    chk("rst_hold", {14'd0, halted, dut_vec}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step_en = 1'b0;
  endtask

  task automatic halt_hold(input int cycles);
    for (int c = 0; c < cycles; c++)
      do_cycle(1'($urandom), 4'($urandom), 17'd0, 1'b1, "halt_hold");
  endtask

  // Bus-driver monitor: at most one of the five bus drivers on every cycle.
  always @(negedge clk) begin
    #2;
    if (mon_en)
      chk("bus1hot", {31'd0, $onehot0({pc_out, ram_out, ir_out, acc_out, alu_out})}, 32'd1);
  end

  initial begin
    logic [3:0] op;
    do_reset();
    mon_en = 1'b1;

    // LDA full sequence, then T1 of the following NOP
    run_instr(4'h1, 1'b0, 1'b0, -1, 0, 1'b0);
    run_instr(4'h0, 1'b0, 1'b0, -1, 0, 1'b0);
    // XOR, then NOT (3 states) followed directly by fetch
    run_instr(4'h6, 1'b0, 1'b0, -1, 0, 1'b0);
    run_instr(4'h7, 1'b0, 1'b0, -1, 0, 1'b0);
    run_instr(4'hE, 1'b0, 1'b0, -1, 0, 1'b0);
    // ADD with a 3-cycle stall while sitting in T4
    run_instr(4'h2, 1'b0, 1'b0, 3, 3, 1'b0);
    run_instr(4'h8, 1'b0, 1'b0, -1, 0, 1'b0);
    // conditional jumps with both flag values
    run_instr(4'hA, 1'b1, 1'b0, -1, 0, 1'b0);
    run_instr(4'hA, 1'b0, 1'b1, -1, 0, 1'b0);
    run_instr(4'hB, 1'b0, 1'b1, -1, 0, 1'b0);
    run_instr(4'hB, 1'b1, 1'b0, -1, 0, 1'b0);
    run_instr(4'h9, 1'b0, 1'b0, -1, 0, 1'b0);
    // HLT: 20 halted cycles, reset exits, fetch restarts at T1
    run_instr(4'hF, 1'b0, 1'b0, -1, 0, 1'b0);
    halt_hold(20);
    do_reset();
    run_instr(4'h3, 1'b0, 1'b0, -1, 0, 1'b0);

    // random instruction stream with random stalls and flags
    for (int k = 0; k < 150; k++) begin
      op = 4'($urandom);
      run_instr(op, 1'($urandom), 1'($urandom), -1, 0, 1'b1);
      if (op == 4'hF) begin
        halt_hold(3);
        do_reset();
      end
    end
    // reset in the middle of an instruction aborts it
    zero_flag = 1'b0;
    do_cycle(1'b1, 4'h2, M_PC_OUT | M_MAR, 1'b0, "abort_t1");
    do_cycle(1'b1, 4'h2, M_RAM_OUT | M_IR_LOAD | M_PC_INC, 1'b0, "abort_t2");
    do_cycle(1'b1, 4'h2, M_IR_OUT | M_MAR, 1'b0, "abort_t3");
    do_reset();
    run_instr(4'h5, 1'b0, 1'b0, -1, 0, 1'b0);

    mon_en = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 The block SHALL have these ports, one per line as name / direction / width / meaning:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- step_en  in  1  advance enable; 0 freezes the sequencer
- ir_opcode  in  4  instruction-register upper nibble
- zero_flag  in  1  accumulator-zero flag
- carry_flag  in  1  ALU carry flag
- pc_out, pc_inc, pc_load  out  1 each  program-counter bus drive / increment / load
- mar_load, ram_out, ram_load  out  1 each  memory address latch / RAM bus drive / RAM write
- ir_load, ir_out  out  1 each  IR load / IR operand-nibble bus drive
- acc_load, acc_out, b_load  out  1 each  accumulator load / drive, B-register load
- alu_out, add_sub, alu0_and, alu1_or, xor_not  out  1 each  ALU bus drive and operation select
- out_load  out  1  output-register load
- halted  out  1  HLT executed
REQ-003 Parameters: none; the data width is fixed at 8 and the opcode width at 4.

Function
REQ-004 The state register SHALL hold one of T1..T6 or HALT, and SHALL advance only on clk edges where step_en=1.
REQ-005 Control outputs SHALL be a combinational decode of state and ir_opcode, gated: all outputs 0 whenever step_en=0 (halted excepted).
REQ-006 Fetch SHALL take two states:
- T1: pc_out, mar_load.
- T2: ram_out, ir_load, pc_inc.
REQ-007 Opcodes (hex) and their execute states:
- 0 NOP: T3 with no outputs.
- 1 LDA: T3 ir_out+mar_load; T4 ram_out+acc_load.
- 2/3/4/5/6 ADD/SUB/AND/OR/XOR: T3 ir_out+mar_load; T4 ram_out+b_load; T5 alu_out+acc_load with the ALU select.
- 7 NOT: T3 alu_out+acc_load.
- 8 STA: T3 ir_out+mar_load; T4 acc_out+ram_load.
- 9 JMP: T3 ir_out+pc_load.
- E OUT: T3 acc_out+out_load.
- F HLT: T3 then HALT.
- C, D: treated as NOP.
REQ-008 ALU select, given as {xor_not,add_sub,alu1_or,alu0_and}, SHALL be 0000 for ADD, 0100 for SUB, 0001 for AND, 0010 for OR, 0011 for XOR and 1011 for NOT; all four bits SHALL be 0 outside the alu_out state.
REQ-009 After the last execute state of an instruction, the next state SHALL be T1; T6 SHALL be unused-safe, returning to T1 with no outputs.
REQ-010 At most one bus driver (pc_out, ram_out, ir_out, acc_out, alu_out) SHALL be asserted in any cycle.
REQ-011 HALT SHALL assert halted=1 and drive all other outputs 0, and SHALL be exited only by reset.
REQ-012 The opcode SHALL be sampled combinationally from T3 onward; a change on ir_opcode during T1/T2 SHALL have no effect.

Reset
REQ-013 While rst_n=0, state SHALL be T1 and every output SHALL be 0, including halted.
REQ-014 Reset asserted mid-instruction or in HALT SHALL abort immediately; the first cycle after release SHALL be T1 fetch.

Configuration
REQ-015 Macro COND_JUMP_EN:
- Defined: opcode A (JZ) SHALL assert ir_out+pc_load in T3 iff zero_flag=1, and opcode B (JC) SHALL do so iff carry_flag=1; otherwise T3 SHALL have no outputs.
- Undefined: A and B SHALL be NOP, and the flag inputs SHALL be ignored but still present.

Structure
REQ-016 Package saw_br_pkg SHALL hold:
- the opcode constants;
- the state enumeration;
- the ALU-select constants.
REQ-017 Sub-module tstate_counter SHALL contain the state register with enable, early-return-to-T1 and halt inputs; control_sequencer SHALL hold the decode.

Verification
REQ-018 Reset, then step_en=1, opcode 1: the bench SHALL see T1 pc_out+mar_load, T2 ram_out+ir_load+pc_inc, T3 ir_out+mar_load, T4 ram_out+acc_load, then T1.
REQ-019 Opcode 6 (XOR): in T5 the bench SHALL see alu_out=1, acc_load=1 and select 0011; opcode 7 SHALL give select 1011 in T3, with the instruction 3 cycles long.
REQ-020 step_en toggled 0 for 3 cycles mid-T4 of ADD: the state SHALL hold, outputs SHALL be 0, and the sequence SHALL resume at T4 with no skipped or duplicated state.
REQ-021 Opcode F: HALT SHALL be reached after T3, with halted=1 for 20 cycles; rst_n pulse low SHALL give halted=0 and T1 on release.
REQ-022 With COND_JUMP_EN defined, opcode A: zero_flag=1 SHALL give pc_load=1 in T3 and zero_flag=0 SHALL give pc_load=0; undefined, opcode A with zero_flag=1 SHALL give pc_load=0.
REQ-023 A bench assertion SHALL check the one-hot-or-zero bus-driver property on every cycle of a random opcode stream.
